// File: rtl/cprv_if_stage.sv
// ---------------------------------------------------------------------------
// cprv_if_stage -- instruction fetch stage
//
// Issues in-order fetch requests from a PC register, pairs each returned
// instruction with the PC it was fetched from, and hands the pair to the ID
// stage through a small output buffer. Redirects flush everything and drop
// responses still in flight for the old path.
//
// Configuration:
//   CPRV_IF_PREFETCH_EN defined   -> DEPTH = 2 (two fetches in flight/buffered)
//   CPRV_IF_PREFETCH_EN undefined -> DEPTH = 1
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req_valid_o    fetch request valid
//   imem_req_ready_i    memory accepts the request
//   imem_req_addr_o     fetch address (the PC register)
//   imem_rsp_valid_i    in-order response valid (no backpressure)
//   imem_rsp_data_i     fetched instruction
//   redirect_valid_i    redirect from a later stage
//   redirect_pc_i       redirect target (low two bits ignored)
//   valid_id_o          instruction valid to ID
//   ready_id_i          ID accepts
//   instr_data_id_o     instruction to ID
//   pc_id_o             PC of instr_data_id_o
// ---------------------------------------------------------------------------
module cprv_if_stage #(
    parameter int unsigned           INSTR_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH  = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req_valid_o,
    input  logic                   imem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr_o,
    input  logic                   imem_rsp_valid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data_i,
    input  logic                   redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    output logic                   valid_id_o,
    input  logic                   ready_id_i,
    output logic [INSTR_WIDTH-1:0] instr_data_id_o,
    output logic [ADDR_WIDTH-1:0]  pc_id_o
);

`ifdef CPRV_IF_PREFETCH_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Ring-pointer advance with explicit wrap (DEPTH need not be a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic                   run_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [CNT_W-1:0]       outstanding_q;
    logic [CNT_W-1:0]       drop_q;

    logic [PTR_W-1:0]       pcq_rd_q;
    logic [PTR_W-1:0]       pcq_wr_q;
    logic [ADDR_WIDTH-1:0]  pcq_mem_q [DEPTH];

    logic [CNT_W-1:0]       buf_cnt_q;
    logic [PTR_W-1:0]       buf_rd_q;
    logic [PTR_W-1:0]       buf_wr_q;
    logic [INSTR_WIDTH-1:0] buf_data_q [DEPTH];
    logic [ADDR_WIDTH-1:0]  buf_pc_q [DEPTH];

    logic                   buf_pop_c;
    logic [CNT_W:0]         credit_used_c;
    logic                   req_fire_c;
    logic                   rsp_drop_c;
    logic                   rsp_keep_c;
    logic [CNT_W-1:0]       outstanding_next_c;
    logic                   unused_redirect_lsbs;

    // Target alignment discards the low two redirect bits
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // ID handshake
    assign buf_pop_c = (buf_cnt_q != '0) && ready_id_i;

    // Credit: slots held by in-flight requests plus buffered instructions.
    // A same-cycle pop frees its slot so back-to-back fetch is sustained.
    assign credit_used_c = (CNT_W+1)'(outstanding_q) + (CNT_W+1)'(buf_cnt_q)
                         - (CNT_W+1)'(buf_pop_c);

    assign imem_req_valid_o = run_q && !redirect_valid_i
                            && (credit_used_c < (CNT_W+1)'(DEPTH));
    assign imem_req_addr_o  = pc_q;
    assign req_fire_c       = imem_req_valid_o && imem_req_ready_i;

    // Responses for the old path (or racing a redirect) are discarded
    assign rsp_drop_c = imem_rsp_valid_i && (redirect_valid_i || (drop_q != '0));
    assign rsp_keep_c = imem_rsp_valid_i && !rsp_drop_c;

    // Every response, kept or dropped, retires one in-flight request
    assign outstanding_next_c = outstanding_q + CNT_W'(req_fire_c)
                              - CNT_W'(imem_rsp_valid_i);

    // ID outputs come straight from buffer flops
    assign valid_id_o      = (buf_cnt_q != '0);
    assign instr_data_id_o = buf_data_q[buf_rd_q];
    assign pc_id_o         = buf_pc_q[buf_rd_q];

    // Fetch, PC queue and output buffer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            pcq_rd_q      <= '0;
            pcq_wr_q      <= '0;
            buf_cnt_q     <= '0;
            buf_rd_q      <= '0;
            buf_wr_q      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pcq_mem_q[i]  <= '0;
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
        end else begin
            run_q         <= 1'b1;
            outstanding_q <= outstanding_next_c;
            if (redirect_valid_i) begin
                pc_q      <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
                pcq_rd_q  <= '0;
                pcq_wr_q  <= '0;
                buf_cnt_q <= '0;
                buf_rd_q  <= '0;
                buf_wr_q  <= '0;
                // Counts what is still in flight after this cycle's response,
                // which is itself dropped here and must not be counted twice
                drop_q    <= outstanding_next_c;
            end else begin
                if (req_fire_c) begin
                    pc_q                <= pc_q + ADDR_WIDTH'(4);
                    pcq_mem_q[pcq_wr_q] <= pc_q;
                    pcq_wr_q            <= ptr_inc(pcq_wr_q);
                end
                if (rsp_keep_c) begin
                    buf_data_q[buf_wr_q] <= imem_rsp_data_i;
                    buf_pc_q[buf_wr_q]   <= pcq_mem_q[pcq_rd_q];
                    buf_wr_q             <= ptr_inc(buf_wr_q);
                    pcq_rd_q             <= ptr_inc(pcq_rd_q);
                end
                if (buf_pop_c) begin
                    buf_rd_q <= ptr_inc(buf_rd_q);
                end
                buf_cnt_q <= buf_cnt_q + CNT_W'(rsp_keep_c) - CNT_W'(buf_pop_c);
                if (imem_rsp_valid_i && (drop_q != '0)) begin
                    drop_q <= drop_q - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cprv_if_stage.sv
// ---------------------------------------------------------------------------
// tb_cprv_if_stage -- self-checking bench for cprv_if_stage
//
// A behavioural memory returns random data in order after a random latency.
// The reference model is a list of fetches accepted on the current path:
// redirects and resets empty it, deliveries must match its front in order,
// and accepted addresses must follow a simple next-PC rule.
// ---------------------------------------------------------------------------
module tb_cprv_if_stage;

`ifdef CPRV_IF_PREFETCH_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam logic [63:0] RST_PC = 64'h0;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [63:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_valid_i;
    logic [63:0] redirect_pc_i;
    logic        valid_id_o;
    logic        ready_id_i;
    logic [31:0] instr_data_id_o;
    logic [63:0] pc_id_o;

    cprv_if_stage #(
        .INSTR_WIDTH (32),
        .ADDR_WIDTH  (64),
        .RESET_PC    (RST_PC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .valid_id_o       (valid_id_o),
        .ready_id_i       (ready_id_i),
        .instr_data_id_o  (instr_data_id_o),
        .pc_id_o          (pc_id_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int unsigned due;
        int unsigned epoch;
    } mreq_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
    } item_t;

    mreq_t       mem_q[$];
    item_t       exp_q[$];
    logic [63:0] exp_addr;
    int unsigned epoch;
    int unsigned cyc;

    int unsigned mem_rdy_pct, id_rdy_pct, redir_pct, lat_min, lat_max;
    logic        force_redir;
    logic [63:0] force_tgt;

    logic        prev_req_stall, prev_id_stall, prev_redir;
    logic [63:0] prev_addr, prev_pc;
    logic [31:0] prev_data;

    int unsigned n_accept, n_deliver;
    logic [63:0] last_acc_addr, last_del_pc;

    int unsigned n_checks;
    int unsigned n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] rand_target();
        logic [3:0] lo;
        lo = 4'($urandom);
        if ($urandom_range(3) == 0) return {60'hFFFF_FFFF_FFFF_FFF, lo};
        return {$urandom, $urandom};
    endfunction

    task automatic set_knobs(input int unsigned mr, input int unsigned lmin,
                             input int unsigned lmax, input int unsigned ir,
                             input int unsigned rr);
        mem_rdy_pct = mr; lat_min = lmin; lat_max = lmax;
        id_rdy_pct = ir; redir_pct = rr;
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then
    // advance the reference model by what the next rising edge will do.
    task automatic cycle();
        logic        accept, deliver, redir;
        logic [63:0] tgt;
        logic [31:0] d;
        int unsigned stale;
        mreq_t       m;
        @(negedge clk);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_q[0].data;
            mem_q.delete(0);
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = $urandom;
        end
        imem_req_ready_i = ($urandom_range(99) < mem_rdy_pct);
        ready_id_i       = ($urandom_range(99) < id_rdy_pct);
        if (force_redir) begin
            redir       = 1'b1;
            tgt         = force_tgt;
            force_redir = 1'b0;
        end else begin
            redir = ($urandom_range(99) < redir_pct);
            tgt   = rand_target();
        end
        redirect_valid_i = redir;
        redirect_pc_i    = tgt;
        #1;
        if (redir) check("req_valid_during_redirect", 64'(imem_req_valid_o), 64'd0);
        if (prev_redir) check("valid_id_after_redirect", 64'(valid_id_o), 64'd0);
        if (prev_req_stall && imem_req_valid_o)
            check("req_addr_stable", imem_req_addr_o, prev_addr);
        if (prev_id_stall && !prev_redir) begin
            check("id_valid_held", 64'(valid_id_o), 64'd1);
            check("id_pc_held", pc_id_o, prev_pc);
            check("id_instr_held", 64'(instr_data_id_o), 64'(prev_data));
        end

        accept  = imem_req_valid_o && imem_req_ready_i;
        deliver = valid_id_o && ready_id_i && !redir;
        if (accept) begin
            check("fetch_addr", imem_req_addr_o, exp_addr);
            last_acc_addr = imem_req_addr_o;
            d       = $urandom;
            m.data  = d;
            m.due   = cyc + 1 + $urandom_range(lat_max, lat_min);
            m.epoch = epoch;
            mem_q.push_back(m);
            exp_q.push_back('{pc: exp_addr, data: d});
            exp_addr = exp_addr + 64'd4;
            n_accept++;
        end
        if (deliver) begin
            if (exp_q.size() == 0) begin
                check("deliver_unexpected", 64'd1, 64'd0);
            end else begin
                check("deliver_pc", pc_id_o, exp_q[0].pc);
                check("deliver_instr", 64'(instr_data_id_o), 64'(exp_q[0].data));
                exp_q.delete(0);
            end
            last_del_pc = pc_id_o;
            n_deliver++;
        end
        if (redir) begin
            epoch++;
            exp_q.delete();
            exp_addr = {tgt[63:2], 2'b00};
        end
        // Fetches in flight for old paths plus current-path work never exceed DEPTH
        stale = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
        check("credit_bound", 64'((stale + exp_q.size()) <= DEPTH), 64'd1);

        prev_req_stall = imem_req_valid_o && !imem_req_ready_i;
        prev_addr      = imem_req_addr_o;
        prev_id_stall  = valid_id_o && !ready_id_i;
        prev_pc        = pc_id_o;
        prev_data      = instr_data_id_o;
        prev_redir     = redir;
        cyc++;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_accept(input string tag);
        int unsigned start, k;
        start = n_accept;
        k     = 0;
        while (n_accept == start && k < 100) begin
            cycle();
            k++;
        end
        if (n_accept == start) check(tag, 64'd0, 64'd1);
    endtask

    task automatic wait_deliver(input string tag);
        int unsigned start, k;
        start = n_deliver;
        k     = 0;
        while (n_deliver == start && k < 100) begin
            cycle();
            k++;
        end
        if (n_deliver == start) check(tag, 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
        check("rst_valid_id", 64'(valid_id_o), 64'd0);
        check("rst_instr", 64'(instr_data_id_o), 64'd0);
        check("rst_pc_id", pc_id_o, 64'd0);
        check("rst_req_addr", imem_req_addr_o, RST_PC);
        mem_q.delete();
        exp_q.delete();
        exp_addr       = RST_PC;
        epoch++;
        prev_req_stall = 1'b0;
        prev_id_stall  = 1'b0;
        prev_redir     = 1'b0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        ready_id_i       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hold_valid_id", 64'(valid_id_o), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned d0, a0;
        n_checks = 0; n_errors = 0; cyc = 0; epoch = 0;
        n_accept = 0; n_deliver = 0;
        force_redir = 1'b0; force_tgt = '0;
        last_acc_addr = '0; last_del_pc = '0;
        prev_addr = '0; prev_pc = '0; prev_data = '0;
        imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
        redirect_valid_i = 1'b0; redirect_pc_i = '0; ready_id_i = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        do_reset();

        // Streaming: mem always ready, 1-cycle latency, ID always ready
        set_knobs(100, 0, 0, 100, 0);
        run(10);
        d0 = n_deliver;
        run(40);
        if (DEPTH == 2) begin
            check("throughput_full", 64'((n_deliver - d0) >= 39), 64'd1);
        end else begin
            check("throughput_half_lo", 64'((n_deliver - d0) >= 19), 64'd1);
            check("throughput_half_hi", 64'((n_deliver - d0) <= 21), 64'd1);
        end

        // ID stalled for 10 cycles: no more than DEPTH fetches issued
        set_knobs(100, 0, 0, 0, 0);
        a0 = n_accept;
        run(10);
        check("stall_accepts", 64'((n_accept - a0) <= DEPTH), 64'd1);
        set_knobs(100, 0, 0, 100, 0);
        run(10);

        // Redirect to a misaligned target with fetches in flight
        set_knobs(100, 4, 4, 100, 0);
        run(3);
        force_redir = 1'b1;
        force_tgt   = 64'h1003;
        wait_accept("redir_accept_timeout");
        check("redir_next_addr", last_acc_addr, 64'h1000);
        wait_deliver("redir_deliver_timeout");
        check("redir_first_pc", last_del_pc, 64'h1000);

        // Redirect racing a response and an ID pop in steady streaming
        set_knobs(100, 0, 0, 100, 0);
        run(10);
        force_redir = 1'b1;
        force_tgt   = 64'h2000;
        wait_accept("race_accept_timeout");
        check("race_next_addr", last_acc_addr, 64'h2000);
        wait_deliver("race_deliver_timeout");
        check("race_first_pc", last_del_pc, 64'h2000);

        // PC wrap at the top of the address space
        force_redir = 1'b1;
        force_tgt   = 64'hFFFF_FFFF_FFFF_FFFF;
        wait_accept("wrap_accept_timeout");
        check("wrap_top_addr", last_acc_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_accept("wrap_accept2_timeout");
        check("wrap_zero_addr", last_acc_addr, 64'h0);
        run(10);

        // Reset with fetches in flight, then restart from RESET_PC
        set_knobs(100, 5, 5, 100, 0);
        run(3);
        do_reset();
        set_knobs(100, 0, 2, 100, 0);
        wait_accept("rst_restart_timeout");
        check("rst_restart_addr", last_acc_addr, RST_PC);
        run(10);

        // Randomised traffic
        for (int s = 0; s < 10; s++) begin
            int unsigned lmin;
            lmin = $urandom_range(2);
            set_knobs($urandom_range(100, 30), lmin, lmin + $urandom_range(4),
                      $urandom_range(100, 20), $urandom_range(8));
            run(300);
        end

        // Drain: stop fetching and let everything reach ID
        set_knobs(0, 0, 0, 100, 0);
        run(60);
        check("drain_model_empty", 64'(exp_q.size()), 64'd0);
        check("drain_mem_empty", 64'(mem_q.size()), 64'd0);
        check("drain_valid_id", 64'(valid_id_o), 64'd0);
        check("progress", 64'(n_deliver > 200), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
